// File: rtl/cam_capture_fifo_regs.sv
// Camera capture block with a Wishbone register slave.
//
// Purpose: oversamples a parallel camera bus in the Wishbone clock domain and packs
// PIX_W-bit pixels into 32-bit words. Words go into a FIFO that the host drains through
// the DATA register. Also provides frame gating, single-shot capture, a sticky overflow
// flag, a frame counter and a level-threshold interrupt.
//
// Ports:
//   WBs_CLK_i, WBs_RSTn_i       sole clock, asynchronous active-low reset
//   WBs_ADR_i .. WBs_DAT_i      Wishbone slave request (word address)
//   WBs_DAT_o, WBs_ACK_o        registered read data, single-cycle acknowledge
//   CAM_PCLK_i                  camera pixel clock, sampled as data (<= WBs_CLK_i/4)
//   CAM_VSYNC_i, CAM_HREF_i     frame valid and line valid, active high
//   CAM_DATA_i                  pixel data
//   IRQ_o                       registered level interrupt
module cam_capture_fifo_regs #(
    parameter int unsigned ADDRWIDTH   = 9,
    parameter int unsigned PIX_W       = 8,
    parameter int unsigned FIFO_AW     = 6,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [ADDRWIDTH-1:0] CTRL_ADR = 9'h0,
    parameter logic [ADDRWIDTH-1:0] STAT_ADR = 9'h1,
    parameter logic [ADDRWIDTH-1:0] DATA_ADR = 9'h2,
    parameter logic [ADDRWIDTH-1:0] THRS_ADR = 9'h3,
    parameter logic [31:0] DEF_REG_VALUE     = 32'hFABD_EFAC
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RSTn_i,
    input  logic [ADDRWIDTH-1:0] WBs_ADR_i,
    input  logic                 WBs_CYC_i,
    input  logic                 WBs_STB_i,
    input  logic                 WBs_WE_i,
    input  logic [3:0]           WBs_BYTE_STB_i,
    input  logic [31:0]          WBs_DAT_i,
    output logic [31:0]          WBs_DAT_o,
    output logic                 WBs_ACK_o,
    input  logic                 CAM_PCLK_i,
    input  logic                 CAM_VSYNC_i,
    input  logic                 CAM_HREF_i,
    input  logic [PIX_W-1:0]     CAM_DATA_i,
    output logic                 IRQ_o
);

    localparam int unsigned DEPTH  = 2 ** FIFO_AW;
    localparam int unsigned LANES  = 32 / PIX_W;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned LVL_W  = FIFO_AW + 1;
    localparam int unsigned CAM_W  = PIX_W + 3;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StWaitFrame = 2'd1,
        StCapture   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Camera input synchronisers and edge detection
    // ------------------------------------------------------------------
    logic [CAM_W-1:0] w_cam_in;
    logic [CAM_W-1:0] r_sync [SYNC_STAGES];
    logic             w_pclk_s;
    logic             w_vsync_s;
    logic             w_href_s;
    logic [PIX_W-1:0] w_data_s;
    logic             r_pclk_d;
    logic             r_vsync_d;
    logic             w_sample;
    logic             w_vs_rise;
    logic             w_vs_fall;

    assign w_cam_in = {CAM_PCLK_i, CAM_VSYNC_i, CAM_HREF_i, CAM_DATA_i};

    always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
        if (!WBs_RSTn_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_pclk_d  <= 1'b0;
            r_vsync_d <= 1'b0;
        end else begin
            r_sync[0] <= w_cam_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_pclk_d  <= w_pclk_s;
            r_vsync_d <= w_vsync_s;
        end
    end

    // All camera fields are taken from the same stage so a sample is coherent.
    assign w_pclk_s  = r_sync[SYNC_STAGES-1][CAM_W-1];
    assign w_vsync_s = r_sync[SYNC_STAGES-1][CAM_W-2];
    assign w_href_s  = r_sync[SYNC_STAGES-1][CAM_W-3];
    assign w_data_s  = r_sync[SYNC_STAGES-1][PIX_W-1:0];

    assign w_sample  = w_pclk_s & ~r_pclk_d;
    assign w_vs_rise = w_vsync_s & ~r_vsync_d;
    assign w_vs_fall = ~w_vsync_s & r_vsync_d;

    // ------------------------------------------------------------------
    // Wishbone decode
    // ------------------------------------------------------------------
    logic r_ack;
    logic w_ack_nxt;
    logic w_wr;
    logic w_rd;
    logic w_sel_ctrl;
    logic w_sel_stat;
    logic w_sel_data;
    logic w_sel_thrs;
    logic w_flush;
    logic w_pop;
    logic w_ovf_clr;

    assign w_ack_nxt  = WBs_CYC_i & WBs_STB_i & ~r_ack;
    assign w_wr       = w_ack_nxt & WBs_WE_i;
    assign w_rd       = w_ack_nxt & ~WBs_WE_i;
    assign w_sel_ctrl = (WBs_ADR_i == CTRL_ADR);
    assign w_sel_stat = (WBs_ADR_i == STAT_ADR);
    assign w_sel_data = (WBs_ADR_i == DATA_ADR);
    assign w_sel_thrs = (WBs_ADR_i == THRS_ADR);

    assign w_flush    = w_wr & w_sel_ctrl & WBs_BYTE_STB_i[0] & WBs_DAT_i[3];
    assign w_ovf_clr  = w_wr & w_sel_stat & WBs_BYTE_STB_i[0] & WBs_DAT_i[3];

    // ------------------------------------------------------------------
    // Control and threshold registers
    // ------------------------------------------------------------------
    logic             r_en;
    logic             r_single;
    logic             r_ie;
    logic [LVL_W-1:0] r_thrs;
    logic [LVL_W-1:0] w_thrs_nxt;
    logic             w_single_done;
    state_t           r_state;

    // A single-shot frame that completes drops EN so the FSM parks in idle.
    assign w_single_done = (r_state == StCapture) & r_en & r_single & w_vs_fall;

    always_comb begin
        w_thrs_nxt = r_thrs;
        for (int i = 0; i < LVL_W; i++) begin
            if (WBs_BYTE_STB_i[i/8]) begin
                w_thrs_nxt[i] = WBs_DAT_i[i];
            end
        end
    end

    always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
        if (!WBs_RSTn_i) begin
            r_en     <= 1'b0;
            r_single <= 1'b0;
            r_ie     <= 1'b0;
            r_thrs   <= '0;
        end else begin
            if (w_wr && w_sel_ctrl && WBs_BYTE_STB_i[0]) begin
                r_en     <= WBs_DAT_i[0];
                r_single <= WBs_DAT_i[1];
                r_ie     <= WBs_DAT_i[2];
            end else if (w_single_done) begin
                r_en <= 1'b0;
            end
            if (w_wr && w_sel_thrs) begin
                r_thrs <= w_thrs_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Capture FSM and pixel packer
    // ------------------------------------------------------------------
    logic [LANE_W-1:0] r_lane;
    logic [31:0]       r_pack;
    logic [31:0]       w_pack_nxt;
    logic              r_push;
    logic [31:0]       r_push_data;
    logic [15:0]       r_frame_cnt;

    always_comb begin
        w_pack_nxt = r_pack;
        w_pack_nxt[32'(r_lane) * PIX_W +: PIX_W] = w_data_s;
    end

    always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
        if (!WBs_RSTn_i) begin
            r_state     <= StIdle;
            r_lane      <= '0;
            r_pack      <= '0;
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_push <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (r_en) begin
                        r_state <= StWaitFrame;
                    end
                end
                StWaitFrame: begin
                    if (!r_en) begin
                        r_state <= StIdle;
                    end else if (w_vs_rise) begin
                        r_state <= StCapture;
                    end
                end
                StCapture: begin
                    if (!r_en) begin
                        // Abort: the partial word is discarded and the frame not counted.
                        r_state <= StIdle;
                        r_lane  <= '0;
                        r_pack  <= '0;
                    end else if (w_vs_fall) begin
                        if (r_lane != '0) begin
                            r_push      <= 1'b1;
                            r_push_data <= r_pack;
                        end
                        r_lane      <= '0;
                        r_pack      <= '0;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_state     <= r_single ? StIdle : StWaitFrame;
                    end else if (w_sample && w_href_s && w_vsync_s) begin
                        if (r_lane == LANE_W'(LANES - 1)) begin
                            r_push      <= 1'b1;
                            r_push_data <= w_pack_nxt;
                            r_pack      <= '0;
                            r_lane      <= '0;
                        end else begin
                            r_pack <= w_pack_nxt;
                            r_lane <= r_lane + LANE_W'(1);
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
            // Flush empties the packer, including a word still on its way to the FIFO.
            if (w_flush) begin
                r_lane <= '0;
                r_pack <= '0;
                r_push <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [31:0]        r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [LVL_W-1:0]   r_level;
    logic               w_full;
    logic               w_empty;
    logic               w_push_ok;
    logic               w_ovf_evt;
    logic               r_ovf;

    assign w_full    = (r_level == LVL_W'(DEPTH));
    assign w_empty   = (r_level == '0);
    assign w_pop     = w_rd & w_sel_data & ~w_empty;
    // A same-cycle pop frees the slot a full FIFO needs.
    assign w_push_ok = r_push & (~w_full | w_pop) & ~w_flush;
    assign w_ovf_evt = r_push & w_full & ~w_pop & ~w_flush;

    always_ff @(posedge WBs_CLK_i) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= r_push_data;
        end
    end

    always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
        if (!WBs_RSTn_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + FIFO_AW'(1);
            end
            if (w_push_ok && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (!w_push_ok && w_pop) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

    // Overflow set beats a same-cycle software clear.
    always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
        if (!WBs_RSTn_i) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_evt) begin
            r_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Interrupt
    // ------------------------------------------------------------------
    logic r_irq;

    always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
        if (!WBs_RSTn_i) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_ie & (r_level >= r_thrs) & (r_thrs != '0);
        end
    end

    // ------------------------------------------------------------------
    // Read mux and bus outputs
    // ------------------------------------------------------------------
    logic [7:0]  w_level8;
    logic [31:0] w_rdata;
    logic [31:0] r_dat;
    logic        w_busy;
    logic        w_unused_bits;

    generate
        if (LVL_W >= 8) begin : g_lvl_trunc
            assign w_level8 = r_level[7:0];
        end else begin : g_lvl_ext
            assign w_level8 = {{(8 - LVL_W){1'b0}}, r_level};
        end
    endgenerate

    assign w_busy = (r_state != StIdle);

    always_comb begin
        w_rdata = DEF_REG_VALUE;
        if (w_sel_ctrl) begin
            w_rdata = {28'd0, 1'b0, r_ie, r_single, r_en};
        end else if (w_sel_stat) begin
            w_rdata = {r_frame_cnt, w_level8, 3'd0, r_irq, r_ovf, w_full, w_empty, w_busy};
        end else if (w_sel_data) begin
            w_rdata = w_empty ? 32'd0 : r_mem[r_rptr];
        end else if (w_sel_thrs) begin
            w_rdata = 32'(r_thrs);
        end
    end

    always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
        if (!WBs_RSTn_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_ack_nxt;
            if (w_ack_nxt) begin
                r_dat <= w_rdata;
            end
        end
    end

    assign WBs_ACK_o = r_ack;
    assign WBs_DAT_o = r_dat;
    assign IRQ_o     = r_irq;

    // Bus bits that only some registers consume.
    assign w_unused_bits = ^{WBs_DAT_i, WBs_BYTE_STB_i};

endmodule

// File: tb/tb_cam_capture_fifo_regs.sv
module tb_cam_capture_fifo_regs;

    localparam int unsigned FIFO_AW = 2;
    localparam int unsigned DEPTH   = 4;
    localparam logic [8:0] CTRL = 9'h0;
    localparam logic [8:0] STAT = 9'h1;
    localparam logic [8:0] DATA = 9'h2;
    localparam logic [8:0] THRS = 9'h3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  wb_adr = '0;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_we = 1'b0;
    logic [3:0]  wb_be = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack;
    logic        cam_pclk = 1'b0;
    logic        cam_vsync = 1'b0;
    logic        cam_href = 1'b0;
    logic [7:0]  cam_data = '0;
    logic        irq;

    int n_checks = 0;
    int n_pass = 0;

    // Scoreboard of words the FIFO is expected to hold.
    logic [31:0] exp_q[$];
    logic [31:0] m_word = '0;
    int          m_lane = 0;
    bit          m_active = 1'b0;

    cam_capture_fifo_regs #(
        .ADDRWIDTH  (9),
        .PIX_W      (8),
        .FIFO_AW    (FIFO_AW),
        .SYNC_STAGES(2)
    ) u_dut (
        .WBs_CLK_i     (clk),
        .WBs_RSTn_i    (rst_n),
        .WBs_ADR_i     (wb_adr),
        .WBs_CYC_i     (wb_cyc),
        .WBs_STB_i     (wb_stb),
        .WBs_WE_i      (wb_we),
        .WBs_BYTE_STB_i(wb_be),
        .WBs_DAT_i     (wb_dat_i),
        .WBs_DAT_o     (wb_dat_o),
        .WBs_ACK_o     (wb_ack),
        .CAM_PCLK_i    (cam_pclk),
        .CAM_VSYNC_i   (cam_vsync),
        .CAM_HREF_i    (cam_href),
        .CAM_DATA_i    (cam_data),
        .IRQ_o         (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic model_push(input logic [31:0] w);
        if (exp_q.size() < DEPTH) exp_q.push_back(w);
    endtask

    task automatic model_pixel(input logic [7:0] d);
        if (m_active) begin
            m_word[m_lane*8 +: 8] = d;
            m_lane++;
            if (m_lane == 4) begin
                model_push(m_word);
                m_word = '0;
                m_lane = 0;
            end
        end
    endtask

    task automatic wb_xfer(input logic [8:0] adr, input logic we, input logic [31:0] d,
                           output logic [31:0] rd);
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        wb_adr = adr; wb_we = we; wb_dat_i = d; wb_be = 4'hF;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wb_ack) begin
                seen = 1'b1;
                break;
            end
        end
        rd = wb_dat_o;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        check("wb_ack", {31'd0, seen}, 32'd1);
    endtask

    task automatic wb_write(input logic [8:0] adr, input logic [31:0] d);
        logic [31:0] dummy;
        wb_xfer(adr, 1'b1, d, dummy);
    endtask

    task automatic wb_check(input string tag, input logic [8:0] adr, input logic [31:0] exp);
        logic [31:0] rd;
        wb_xfer(adr, 1'b0, 32'd0, rd);
        check(tag, rd, exp);
    endtask

    task automatic read_data(input string tag);
        logic [31:0] rd;
        logic [31:0] exp;
        wb_xfer(DATA, 1'b0, 32'd0, rd);
        exp = (exp_q.size() == 0) ? 32'd0 : exp_q.pop_front();
        check(tag, rd, exp);
    endtask

    task automatic cam_pixel(input logic [7:0] d);
        @(negedge clk);
        cam_data = d; cam_href = 1'b1;
        repeat (3) @(negedge clk);
        cam_pclk = 1'b1;
        repeat (4) @(negedge clk);
        cam_pclk = 1'b0;
        model_pixel(d);
    endtask

    task automatic cam_line(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) cam_pixel(base + 8'(i));
        @(negedge clk);
        cam_href = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_start();
        m_active = 1'b1; m_word = '0; m_lane = 0;
        @(negedge clk);
        cam_vsync = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic frame_end();
        @(negedge clk);
        cam_href = 1'b0; cam_vsync = 1'b0;
        repeat (8) @(negedge clk);
        if (m_active && m_lane != 0) model_push(m_word);
        m_active = 1'b0; m_word = '0; m_lane = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_dat_o", wb_dat_o, 32'd0);
        check("rst_ack", {31'd0, wb_ack}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        wb_check("rst_status", STAT, 32'h0000_0002);
        wb_check("rst_ctrl", CTRL, 32'd0);

        // Two lines of four pixels
        wb_write(CTRL, 32'h1);
        frame_start();
        cam_line(8'h01, 4);
        cam_line(8'h05, 4);
        frame_end();
        wb_check("f1_status", STAT, 32'h0001_0201);
        read_data("f1_word0");
        read_data("f1_word1");
        read_data("f1_empty_read");

        // Single shot, partial word
        wb_write(CTRL, 32'h3);
        frame_start();
        cam_line(8'hA1, 5);
        frame_end();
        wb_check("single_ctrl", CTRL, 32'h2);
        wb_check("single_status", STAT, 32'h0002_0200);
        read_data("single_word0");
        read_data("single_word1");

        // Overflow: six words into a four-deep FIFO
        wb_write(CTRL, 32'h1);
        frame_start();
        cam_line(8'h10, 24);
        frame_end();
        wb_check("ovf_status", STAT, 32'h0003_040D);
        wb_write(STAT, 32'h8);
        wb_check("ovf_cleared", STAT, 32'h0003_0405);
        for (int i = 0; i < 4; i++) read_data("ovf_word");

        // Threshold interrupt
        wb_write(THRS, 32'h3);
        wb_write(CTRL, 32'h5);
        frame_start();
        cam_line(8'h30, 8);
        repeat (4) @(negedge clk);
        check("irq_below", {31'd0, irq}, 32'd0);
        cam_line(8'h38, 4);
        repeat (2) @(negedge clk);
        check("irq_at_thrs", {31'd0, irq}, 32'd1);
        wb_check("irq_status", STAT, 32'h0003_0311);
        frame_end();
        read_data("irq_word0");
        repeat (3) @(negedge clk);
        check("irq_after_pop", {31'd0, irq}, 32'd0);
        read_data("irq_word1");
        read_data("irq_word2");

        // EN dropped mid-line
        wb_write(CTRL, 32'h1);
        frame_start();
        cam_pixel(8'h50);
        cam_pixel(8'h51);
        wb_write(CTRL, 32'h0);
        m_active = 1'b0;
        cam_pixel(8'h52);
        cam_pixel(8'h53);
        frame_end();
        wb_check("abort_status", STAT, 32'h0004_0002);
        read_data("abort_empty_read");

        // Flush with three words buffered
        wb_write(CTRL, 32'h1);
        frame_start();
        cam_line(8'h60, 12);
        frame_end();
        wb_check("flush_pre", STAT, 32'h0005_0301);
        wb_write(CTRL, 32'h9);
        exp_q.delete();
        wb_check("flush_post", STAT, 32'h0005_0003);
        wb_check("flush_ctrl", CTRL, 32'h1);
        read_data("flush_empty_read");

        // Asynchronous reset mid-frame
        wb_write(THRS, 32'h1);
        wb_write(CTRL, 32'h5);
        frame_start();
        cam_line(8'h70, 4);
        repeat (2) @(negedge clk);
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        cam_pixel(8'h74);
        wb_check("pre_rst_ctrl", CTRL, 32'h5);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_irq", {31'd0, irq}, 32'd0);
        check("rst_mid_dat", wb_dat_o, 32'd0);
        check("rst_mid_ack", {31'd0, wb_ack}, 32'd0);
        exp_q.delete();
        m_active = 1'b0;
        cam_href = 1'b0; cam_vsync = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        wb_check("post_rst_status", STAT, 32'h0000_0002);
        wb_check("post_rst_ctrl", CTRL, 32'd0);
        wb_check("post_rst_thrs", THRS, 32'd0);
        read_data("post_rst_data");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
